// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted round-robin drain of two virtual-channel FIFOs into
// one downstream FIFO. VC0 wins up to VC0_WEIGHT consecutive grants while
// VC1 is waiting; VC1 then gets one grant. Pop strobes are combinational,
// the write to the downstream FIFO is registered two cycles after the pop.
module vc_arbiter #(
    parameter int BW         = 4,
    parameter int VC0_WEIGHT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vc0_fifo_empty,
    input  logic          vc1_fifo_empty,
    input  logic [BW-1:0] vc0_fifo_data_out,
    input  logic [BW-1:0] vc1_fifo_data_out,
    input  logic          out_fifo_almost_full,
    input  logic          out_fifo_full,
    output logic          vc0_fifo_rd,
    output logic          vc1_fifo_rd,
    output logic          out_fifo_wr,
    output logic [BW-1:0] out_fifo_data_in,
    output logic          arb_error
);

    // State doubles as the pending-capture tag: POP0/POP1 in cycle N+1 means
    // the matching VC's read data is valid now and must be captured.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP0 = 2'd1,
        POP1 = 2'd2
    } state_t;

    localparam logic [3:0] WEIGHT = 4'(VC0_WEIGHT);

    state_t        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic          out_wr_q, out_wr_d;
    logic [BW-1:0] out_data_q, out_data_d;
    logic          arb_err_q, arb_err_d;
    logic          grant0, grant1;

    // Grant decision, weight counter update and next state from current inputs
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = IDLE;
        wcnt_d  = wcnt_q;
        if (!reset && !out_fifo_almost_full) begin
            if (!vc0_fifo_empty && vc1_fifo_empty) begin
                grant0 = 1'b1;
            end else if (vc0_fifo_empty && !vc1_fifo_empty) begin
                grant1 = 1'b1;
            end else if (!vc0_fifo_empty && !vc1_fifo_empty) begin
                if (wcnt_q < WEIGHT) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
        end
        if (grant0) begin
            state_d = POP0;
            // Only consecutive VC0 grants that actually starve VC1 count
            if (!vc1_fifo_empty) begin
                wcnt_d = wcnt_q + 4'd1;
            end
        end else if (grant1) begin
            state_d = POP1;
            wcnt_d  = 4'd0;
        end
    end

    // Capture of the popped word and sticky overflow detection
    always_comb begin
        out_wr_d   = 1'b0;
        out_data_d = out_data_q;
        case (state_q)
            POP0: begin
                out_wr_d   = 1'b1;
                out_data_d = vc0_fifo_data_out;
            end
            POP1: begin
                out_wr_d   = 1'b1;
                out_data_d = vc1_fifo_data_out;
            end
            default: begin
            end
        endcase
        arb_err_d = arb_err_q | (out_wr_q & out_fifo_full);
    end

    // State, counter and output registers; reset discards in-flight captures
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wcnt_q     <= 4'd0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            arb_err_q  <= arb_err_d;
        end
    end

    assign vc0_fifo_rd      = grant0;
    assign vc1_fifo_rd      = grant1;
    assign out_fifo_wr      = out_wr_q;
    assign out_fifo_data_in = out_data_q;
    assign arb_error        = arb_err_q;

endmodule
